alu_job_sequencer: RTL and testbench

ALU_JOB_SEQUENCER -- requirements
Module: alu_job_sequencer

---
 rtl/alu_job_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_job_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_job_sequencer.sv
// Sequencer between an SPI operand slave and a float ALU: synchronises the chip
// select and opcode, runs one timed ALU job per transfer and packs a result record.
module alu_job_sequencer #(
  parameter int ALU_LATENCY = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_cs,
  input  logic [2:0]  op_sel,
  input  logic [31:0] operand1_in,
  input  logic [31:0] operand2_in,
  output logic [31:0] alu_n1,
  output logic [31:0] alu_n2,
  output logic [1:0]  alu_oper,
  input  logic [31:0] alu_result,
  output logic [63:0] packed_result,
  output logic        job_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    EXEC    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY - 1);

  state_t                       state_q, state_d;
  logic [SYNC_STAGES-1:0]       cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0][2:0]  op_sync_q, op_sync_d;
  logic                         cs_prev_q, cs_prev_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic [31:0]                  n1_q, n1_d;
  logic [31:0]                  n2_q, n2_d;
  logic [2:0]                   op_q, op_d;
  logic [7:0]                   seq_q, seq_d;
  logic                         overrun_q, overrun_d;
  logic [63:0]                  packed_q, packed_d;
  logic                         job_valid_q, job_valid_d;
  logic                         cs_rise;
  logic [31:0]                  result_v;

  // Flags are {NaN, Inf, zero, sign} of an IEEE-754 single.
  function automatic logic [3:0] fp_flags(input logic [31:0] v);
    logic exp_ones;
    logic man_zero;
    exp_ones = (v[30:23] == 8'hFF);
    man_zero = (v[22:0] == 23'd0);
    return {exp_ones & ~man_zero, exp_ones & man_zero, (v[30:0] == 31'd0), v[31]};
  endfunction

  assign cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
  assign op_sync_d = {op_sync_q[SYNC_STAGES-2:0], op_sel};
  assign cs_prev_d = cs_sync_q[SYNC_STAGES-1];
  assign cs_rise   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n1_d        = n1_q;
    n2_d        = n2_q;
    op_d        = op_q;
    seq_d       = seq_q;
    overrun_d   = overrun_q;
    packed_d    = packed_q;
    job_valid_d = 1'b0;
    result_v    = alu_result;
    case (state_q)
      IDLE: begin
        if (cs_rise) state_d = CAPTURE;
      end
      CAPTURE: begin
        n1_d    = operand1_in;
        n2_d    = operand2_in;
        op_d    = op_sync_q[SYNC_STAGES-1];
        cnt_d   = LAT_LOAD;
        state_d = EXEC;
        if (cs_rise) overrun_d = 1'b1;
      end
      EXEC: begin
        if (cs_rise) overrun_d = 1'b1;
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE: begin
        // Illegal opcodes keep the previous result word; flags follow what is stored.
        result_v    = op_q[2] ? packed_q[31:0] : alu_result;
        seq_d       = seq_q + 8'd1;
        packed_d    = {seq_d, op_q, op_q[2], fp_flags(result_v),
                       overrun_q | cs_rise, 15'd0, result_v};
        job_valid_d = 1'b1;
        overrun_d   = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cs_sync_q   <= '1;
      op_sync_q   <= '0;
      cs_prev_q   <= 1'b1;
      cnt_q       <= '0;
      n1_q        <= '0;
      n2_q        <= '0;
      op_q        <= '0;
      seq_q       <= '0;
      overrun_q   <= 1'b0;
      packed_q    <= '0;
      job_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      op_sync_q   <= op_sync_d;
      cs_prev_q   <= cs_prev_d;
      cnt_q       <= cnt_d;
      n1_q        <= n1_d;
      n2_q        <= n2_d;
      op_q        <= op_d;
      seq_q       <= seq_d;
      overrun_q   <= overrun_d;
      packed_q    <= packed_d;
      job_valid_q <= job_valid_d;
    end
  end

  assign alu_n1        = n1_q;
  assign alu_n2        = n2_q;
  assign alu_oper      = op_q[1:0];
  assign packed_result = packed_q;
  assign job_valid     = job_valid_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_job_sequencer.sv
// Scoreboard bench for alu_job_sequencer: stimulus queues expected job records,
// a monitor pops and compares them (data and arrival cycle) on every job_valid.
module tb_alu_job_sequencer;

  localparam int LAT  = 4;
  localparam int SYNC = 2;
  localparam int JOB_DELAY = SYNC + LAT + 3;

  typedef struct {
    logic [63:0] data;
    int          cycle;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_cs = 1'b1;
  logic [2:0]  op_sel = 3'd0;
  logic [31:0] operand1_in = '0;
  logic [31:0] operand2_in = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] alu_n1, alu_n2;
  logic [1:0]  alu_oper;
  logic [63:0] packed_result;
  logic        job_valid, busy;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total_cnt = 0;
  int   pass_cnt = 0;

  alu_job_sequencer #(.ALU_LATENCY(LAT), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .spi_cs(spi_cs), .op_sel(op_sel),
    .operand1_in(operand1_in), .operand2_in(operand2_in),
    .alu_n1(alu_n1), .alu_n2(alu_n2), .alu_oper(alu_oper),
    .alu_result(alu_result), .packed_result(packed_result),
    .job_valid(job_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", nm, act, req);
  endtask

  // Monitor: every job_valid pulse must match the oldest queued record.
  always @(negedge clk) begin
    if (job_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("[TB] FAIL unexpected_job_valid: got packed 0x%016h at cycle %0d, expected no pulse",
                 packed_result, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput({e.name, "_data"}, packed_result, e.data);
        checkOutput({e.name, "_cycle"}, 64'(cyc), 64'(e.cycle));
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                               input logic [31:0] res, input logic [63:0] exp_data,
                               input string nm, input bit overrun);
    exp_t e;
    @(posedge clk); #1;
    spi_cs = 1'b0; operand1_in = a; operand2_in = b; op_sel = op; alu_result = res;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    spi_cs = 1'b1;
    e.data = exp_data; e.cycle = cyc + JOB_DELAY; e.name = nm;
    exp_q.push_back(e);
    if (overrun) begin
      @(posedge clk); #1; spi_cs = 1'b0;
      @(posedge clk); #1; spi_cs = 1'b1;
    end
    repeat (JOB_DELAY + 3) @(posedge clk);
  endtask

  initial begin
    // Reset with chip select held high: no spurious job.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_packed", packed_result, 64'd0);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("idle_packed", packed_result, 64'd0);

    applyStimulus(32'h3F800000, 32'h40000000, 3'b001, 32'h40400000,
                  64'h01200000_40400000, "basic_add", 1'b0);
    checkOutput("hold_n1", 64'(alu_n1), 64'h3F800000);
    checkOutput("hold_n2", 64'(alu_n2), 64'h40000000);
    checkOutput("hold_oper", 64'(alu_oper), 64'd1);

    applyStimulus(32'h11111111, 32'h22222222, 3'b001, 32'h40000000,
                  64'h02208000_40000000, "overrun", 1'b1);
    applyStimulus(32'h33333333, 32'h44444444, 3'b010, 32'h3F800000,
                  64'h03400000_3F800000, "after_overrun", 1'b0);
    applyStimulus(32'h0, 32'h0, 3'b011, 32'h40400000,
                  64'h04600000_40400000, "prior_result", 1'b0);
    applyStimulus(32'h0, 32'h0, 3'b100, 32'hDEADBEEF,
                  64'h05900000_40400000, "illegal_op", 1'b0);
    checkOutput("illegal_oper", 64'(alu_oper), 64'd0);
    applyStimulus(32'h0, 32'h0, 3'b000, 32'h7FC00000,
                  64'h06080000_7FC00000, "flag_nan", 1'b0);
    applyStimulus(32'h0, 32'h0, 3'b001, 32'hFF800000,
                  64'h07250000_FF800000, "flag_neg_inf", 1'b0);
    applyStimulus(32'h0, 32'h0, 3'b010, 32'h80000000,
                  64'h08430000_80000000, "flag_neg_zero", 1'b0);
    applyStimulus(32'h0, 32'h0, 3'b111, 32'h12345678,
                  64'h09F30000_80000000, "illegal_keeps_flags", 1'b0);

    // Reset pulsed while a job is in EXEC: job aborted, everything cleared.
    @(posedge clk); #1;
    spi_cs = 1'b0; operand1_in = 32'hAAAA5555; op_sel = 3'b001; alu_result = 32'h40400000;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    spi_cs = 1'b1;
    repeat (SYNC + 3) @(posedge clk);
    #1;
    checkOutput("midjob_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_packed", packed_result, 64'd0);
    checkOutput("abort_n1", 64'(alu_n1), 64'd0);
    checkOutput("abort_oper", 64'(alu_oper), 64'd0);
    checkOutput("abort_valid", 64'(job_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);

    // 256 back-to-back legal jobs from reset: sequence wraps to 0 on the last.
    for (int i = 1; i <= 256; i++) begin
      logic [2:0]  op;
      logic [31:0] res;
      logic [7:0]  seq;
      op  = 3'(i % 4);
      res = 32'h3F800000 + 32'(i);
      seq = 8'(i);
      applyStimulus(32'(i), 32'(i * 3), op, res,
                    {seq, op, 21'd0, res}, $sformatf("seq_job_%0d", i), 1'b0);
    end
    checkOutput("wrap_seq_field", 64'(packed_result[63:56]), 64'd0);

    repeat (20) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
